// File: rtl/rot_pkg.sv
// rot_pkg: shared definitions for the rotate-command issue path.
//   ROT_W / ROT_AMT_W : rotator operand and count widths
//   DIR_RIGHT/DIR_LEFT: encoding of the direction control
//   rot_cmd_t         : one queued command, amount already reduced mod 4
package rot_pkg;

  localparam int   ROT_W     = 4;
  localparam int   ROT_AMT_W = 3;
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef struct packed {
    logic [ROT_W-1:0] operand;
    logic             dir;
    logic [1:0]       amount;
  } rot_cmd_t;

endpackage

// File: rtl/rot_cmd_fifo.sv
// rot_cmd_fifo: synchronous FIFO of rot_cmd_t entries.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push, data : write request and entry (ignored while full)
//   pop        : read request (ignored while empty)
//   head       : entry at the read pointer (undefined content while empty)
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
// Handshake: a push takes effect only when !full, a pop only when !empty;
// both may occur in the same cycle.
module rot_cmd_fifo
  import rot_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  rot_cmd_t                 data,
  input  logic                     pop,
  output rot_cmd_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW:0] wr_ptr;
  logic [PW:0] rd_ptr;
  rot_cmd_t    mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are never observed while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= data;
  end

endmodule

// File: rtl/rot_cmd_sequencer.sv
// rot_cmd_sequencer: queues rotate commands and issues one per cycle to an
// external combinational 4-bit rotator, registering its result.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   in_valid/in_ready                : command handshake (in_ready = FIFO not full)
//   in_operand/in_dir/in_amount      : command fields; amount is taken mod 4
//   rot_operand/rot_dir/rot_amount   : rotator inputs, FIFO head or all 0 when empty
//   rot_result                       : rotator output
//   out_valid/out_ready              : result handshake
//   out_data/out_dir                 : registered result and its direction
// Handshakes: a transfer happens on a rising edge where valid && ready; a
// valid side holds its data stable until the transfer.
// Optional build macro ROT_SEQ_STATS_EN adds cmd_count (issues, wraps at
// 16 bits) and fifo_level (current occupancy).
module rot_cmd_sequencer
  import rot_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AMT_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROT_W-1:0]       in_operand,
  input  logic                   in_dir,
  input  logic [AMT_W-1:0]       in_amount,
  output logic [ROT_W-1:0]       rot_operand,
  output logic                   rot_dir,
  output logic [ROT_AMT_W-1:0]   rot_amount,
  input  logic [ROT_W-1:0]       rot_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ROT_W-1:0]       out_data,
  output logic                   out_dir
`ifdef ROT_SEQ_STATS_EN
  ,
  output logic [15:0]            cmd_count,
  output logic [$clog2(DEPTH):0] fifo_level
`endif
);

  rot_cmd_t                 push_cmd;
  rot_cmd_t                 head;
  logic                     full;
  logic                     empty;
  logic                     issue;
  logic [$clog2(DEPTH):0]   level;

  // Only the low two amount bits matter: rotating a 4-bit value by n is
  // the same as rotating by n mod 4.
  assign push_cmd.operand = in_operand;
  assign push_cmd.dir     = in_dir;
  assign push_cmd.amount  = in_amount[1:0];

  generate
    if (AMT_W > 2) begin : g_amt_hi
      logic unused_amt_hi;
      assign unused_amt_hi = ^in_amount[AMT_W-1:2];
    end
  endgenerate

  rot_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .data  (push_cmd),
    .pop   (issue),
    .head  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign in_ready = !full;

  // Rotator lines are forced to zero while empty so no stale entry shows.
  assign rot_operand = empty ? '0   : head.operand;
  assign rot_dir     = empty ? 1'b0 : head.dir;
  assign rot_amount  = empty ? '0   : {1'b0, head.amount};

  // Issue whenever the output register is free or being drained this cycle.
  assign issue = !empty && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_dir   <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_data  <= rot_result;
      out_dir   <= head.dir;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ROT_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_count <= '0;
    end else if (issue) begin
      cmd_count <= cmd_count + 16'd1;
    end
  end

  assign fifo_level = level;
`else
  logic [$clog2(DEPTH):0] unused_level;
  assign unused_level = level;
`endif

endmodule

// File: tb/tb_rot_cmd_sequencer.sv
// tb_rot_cmd_sequencer: directed bench for rot_cmd_sequencer with a
// behavioural 4-bit rotator closing the rot_* -> rot_result loop.
module tb_rot_cmd_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_operand;
  logic       in_dir;
  logic [2:0] in_amount;
  logic [3:0] rot_operand;
  logic       rot_dir;
  logic [2:0] rot_amount;
  logic [3:0] rot_result;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_dir;
`ifdef ROT_SEQ_STATS_EN
  logic [15:0] cmd_count;
  logic [2:0]  fifo_level;
`endif

  int checks = 0;
  int errors = 0;

  // {dir, data} of results expected on the output port, in order
  logic [4:0] exp_q[$];

  rot_cmd_sequencer #(.DEPTH(4), .AMT_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_operand  (in_operand),
    .in_dir      (in_dir),
    .in_amount   (in_amount),
    .rot_operand (rot_operand),
    .rot_dir     (rot_dir),
    .rot_amount  (rot_amount),
    .rot_result  (rot_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_dir     (out_dir)
`ifdef ROT_SEQ_STATS_EN
    ,
    .cmd_count   (cmd_count),
    .fifo_level  (fifo_level)
`endif
  );

  // Behavioural rotator: 0 = right, 1 = left.
  always_comb begin
    logic [7:0] dbl;
    dbl = {rot_operand, rot_operand};
    if (rot_dir) dbl = dbl << rot_amount;
    else         dbl = dbl >> rot_amount;
    rot_result = rot_dir ? dbl[7:4] : dbl[3:0];
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [3:0] op, input logic dir, input logic [2:0] amt);
    in_valid   = 1'b1;
    in_operand = op;
    in_dir     = dir;
    in_amount  = amt;
  endtask

  task automatic idle_in();
    in_valid   = 1'b0;
    in_operand = 4'h0;
    in_dir     = 1'b0;
    in_amount  = 3'd0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b0;
    idle_in();
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    checks++;
    if ({rot_operand, rot_dir, rot_amount} !== 8'h00) begin
      errors++; $display("FAIL reset_rot_lines: got %0h expected 0", {rot_operand, rot_dir, rot_amount});
    end
    checks++;
    if ({out_dir, out_data} !== 5'h00) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", {out_dir, out_data}); end
`ifdef ROT_SEQ_STATS_EN
    checks++;
    if (cmd_count !== 16'd0) begin errors++; $display("FAIL reset_cmd_count: got %0d expected 0", cmd_count); end
`endif
    rst = 1'b0;
    step();
  endtask

  // One command at a time into an idle sequencer: checks latency and the
  // amount reduction visible on the rotator lines.
  task automatic test_single();
    logic [3:0] ops  [3] = '{4'b0110, 4'b1110, 4'b1011};
    logic       dirs [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0] amts [3] = '{3'd2, 3'd3, 3'd6};
    logic [2:0] ramt [3] = '{3'd2, 3'd3, 3'd2};
    logic [3:0] res  [3] = '{4'b1001, 4'b0111, 4'b1110};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cmd(ops[i], dirs[i], amts[i]);
      step();
      idle_in();
      checks++;
      if ({rot_operand, rot_dir, rot_amount} !== {ops[i], dirs[i], ramt[i]}) begin
        errors++; $display("FAIL single_rot_lines[%0d]: got %0h expected %0h", i,
                            {rot_operand, rot_dir, rot_amount}, {ops[i], dirs[i], ramt[i]});
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass[%0d]: got %0b expected 0", i, out_valid); end
      step();
      checks++;
      if ({out_valid, out_dir, out_data} !== {1'b1, dirs[i], res[i]}) begin
        errors++; $display("FAIL single_result[%0d]: got %0h expected %0h", i,
                            {out_valid, out_dir, out_data}, {1'b1, dirs[i], res[i]});
      end
      checks++;
      if ({rot_operand, rot_dir, rot_amount} !== 8'h00) begin
        errors++; $display("FAIL single_rot_empty[%0d]: got %0h expected 0", i, {rot_operand, rot_dir, rot_amount});
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain[%0d]: got %0b expected 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] ops  [5] = '{4'b0001, 4'b0011, 4'b1000, 4'b1100, 4'b0101};
    logic       dirs [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] amts [5] = '{3'd1, 3'd1, 3'd5, 3'd2, 3'd0};
    logic [3:0] res  [5] = '{4'b1000, 4'b0110, 4'b0100, 4'b0011, 4'b0101};
    logic [4:0] exp;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_cmd(ops[i], dirs[i], amts[i]);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_fill[%0d]: got %0b expected 1", i, in_ready); end
      exp_q.push_back({dirs[i], res[i]});
      step();
    end
    idle_in();
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %0b expected 0", in_ready); end
`ifdef ROT_SEQ_STATS_EN
    checks++;
    if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp_level: got %0d expected 4", fifo_level); end
`endif
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({out_valid, out_dir, out_data} !== {1'b1, 1'b0, 4'b1000}) begin
        errors++; $display("FAIL bp_hold[%0d]: got %0h expected %0h", k, {out_valid, out_dir, out_data}, 6'b101000);
      end
      step();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp = exp_q.pop_front();
      checks++;
      if ({out_valid, out_dir, out_data} !== {1'b1, exp}) begin
        errors++; $display("FAIL bp_drain[%0d]: got %0h expected %0h", k, {out_valid, out_dir, out_data}, {1'b1, exp});
      end
      step();
    end
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL bp_empty: got valid %0b queue %0d expected 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_streaming();
    logic [3:0] ops  [8] = '{4'b1001, 4'b1001, 4'b0111, 4'b0111, 4'b1111, 4'b0010, 4'b1010, 4'b0001};
    logic       dirs [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [2:0] amts [8] = '{3'd1, 3'd1, 3'd2, 3'd7, 3'd3, 3'd4, 3'd1, 3'd2};
    logic [3:0] res  [8] = '{4'b1100, 4'b0011, 4'b1101, 4'b1011, 4'b1111, 4'b0010, 4'b0101, 4'b0100};
    logic [4:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        drive_cmd(ops[i], dirs[i], amts[i]);
        exp_q.push_back({dirs[i], res[i]});
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %0b expected 1", i, in_ready); end
      end else begin
        idle_in();
      end
      step();
      if (i >= 1 && i <= 8) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 5'h1f;
        checks++;
        if ({out_valid, out_dir, out_data} !== {1'b1, exp}) begin
          errors++; $display("FAIL stream_result[%0d]: got %0h expected %0h", i - 1, {out_valid, out_dir, out_data}, {1'b1, exp});
        end
      end else if (i == 9) begin
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain: got %0b expected 0", out_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_cmd(4'b1010, 1'b0, 3'd1); step();
    drive_cmd(4'b0110, 1'b1, 3'd3); step();
    drive_cmd(4'b1100, 1'b0, 3'd2); step();
    drive_cmd(4'b0011, 1'b1, 3'd1); step();
    idle_in();
    checks++;
    if ({out_valid, rot_operand, rot_dir} !== {1'b1, 4'b0110, 1'b1}) begin
      errors++; $display("FAIL mid_pre_reset: got %0h expected %0h", {out_valid, rot_operand, rot_dir}, 6'b101101);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %0b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %0b expected 1", in_ready); end
    checks++;
    if ({rot_operand, rot_dir, rot_amount, out_data} !== 12'h000) begin
      errors++; $display("FAIL mid_rot_lines: got %0h expected 0", {rot_operand, rot_dir, rot_amount, out_data});
    end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %0b expected 0", k, out_valid); end
    end
  endtask

`ifdef ROT_SEQ_STATS_EN
  task automatic test_stats();
    test_streaming();
    checks++;
    if (cmd_count !== 16'd8) begin errors++; $display("FAIL stats_count8: got %0d expected 8", cmd_count); end
    checks++;
    if (fifo_level !== 3'd0) begin errors++; $display("FAIL stats_level0: got %0d expected 0", fifo_level); end
    out_ready = 1'b1;
    drive_cmd(4'b0001, 1'b0, 3'd0);
    for (int i = 0; i < 65527; i++) step();
    idle_in();
    step();
    step();
    checks++;
    if (cmd_count !== 16'd65535) begin errors++; $display("FAIL stats_count_max: got %0d expected 65535", cmd_count); end
    drive_cmd(4'b0001, 1'b0, 3'd0);
    step();
    idle_in();
    step();
    checks++;
    if (cmd_count !== 16'd0) begin errors++; $display("FAIL stats_wrap: got %0d expected 0", cmd_count); end
  endtask
`endif

  initial begin
    exp_q.delete();
    test_reset();
    test_single();
    test_backpressure();
    exp_q.delete();
    test_streaming();
    exp_q.delete();
    test_reset_mid();
`ifdef ROT_SEQ_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
